// File: rtl/seq_divider.sv
// Sequential signed divider: one restoring step per clock, then a sign-fixup cycle.
// Ports:
//   wClk, reset        clock and synchronous active-high reset
//   start              request, sampled only while busy=0
//   xDvd, xDvs         dividend / divisor, captured on an accepted start
//   xQuot, xRem        registered quotient / remainder (truncating toward zero)
//   busy               high from the cycle after acceptance through the fixup edge
//   done               one-cycle pulse when results become valid
//   divByZero, ovf     status of the last completed division, held with results
module seq_divider #(
  parameter int unsigned NBITS = 16
) (
  input  logic             wClk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] xDvd,
  input  logic [NBITS-1:0] xDvs,
  output logic [NBITS-1:0] xQuot,
  output logic [NBITS-1:0] xRem,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(NBITS + 1);
  localparam logic [NBITS-1:0] MIN_NEG = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_STEP = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [NBITS:0]   acc;       // partial remainder A
  logic [NBITS-1:0] quo;       // Q: dividend magnitude shifting out, quotient bits shifting in
  logic [NBITS-1:0] dvs_mag;   // divisor magnitude D
  logic [NBITS-1:0] dvd_cap;   // raw dividend, returned as remainder on divide-by-zero
  logic             neg_dvd;
  logic             neg_quo;
  logic             ovf_cap;
  logic [CW-1:0]    cnt;

  logic [NBITS:0]   shift_c;
  logic [NBITS:0]   diff_c;
  logic             ge_c;
  logic [NBITS-1:0] dvd_mag_c;
  logic [NBITS-1:0] dvs_mag_c;

  // One restoring step: shift {A,Q} left, trial-subtract D
  always_comb begin
    shift_c = {acc[NBITS-1:0], quo[NBITS-1]};
    ge_c    = (shift_c >= {1'b0, dvs_mag});
    diff_c  = shift_c - {1'b0, dvs_mag};
  end

  // Operand magnitudes as unsigned NBITS values (most-negative maps to itself)
  always_comb begin
    dvd_mag_c = xDvd[NBITS-1] ? (NBITS'(0) - xDvd) : xDvd;
    dvs_mag_c = xDvs[NBITS-1] ? (NBITS'(0) - xDvs) : xDvs;
  end

  // Control FSM and datapath registers
  always_ff @(posedge wClk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      quo       <= '0;
      dvs_mag   <= '0;
      dvd_cap   <= '0;
      neg_dvd   <= 1'b0;
      neg_quo   <= 1'b0;
      ovf_cap   <= 1'b0;
      cnt       <= '0;
      xQuot     <= '0;
      xRem      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            quo     <= dvd_mag_c;
            dvs_mag <= dvs_mag_c;
            dvd_cap <= xDvd;
            neg_dvd <= xDvd[NBITS-1];
            neg_quo <= xDvd[NBITS-1] ^ xDvs[NBITS-1];
            ovf_cap <= (xDvd == MIN_NEG) && (xDvs == '1);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          acc <= ge_c ? diff_c : shift_c;
          quo <= {quo[NBITS-2:0], ge_c};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dvs_mag == '0) begin
            xQuot     <= '1;
            xRem      <= dvd_cap;
            divByZero <= 1'b1;
            ovf       <= 1'b0;
          end else if (ovf_cap) begin
            xQuot     <= MIN_NEG;
            xRem      <= '0;
            divByZero <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            xQuot     <= neg_quo ? (NBITS'(0) - quo) : quo;
            xRem      <= neg_dvd ? (NBITS'(0) - acc[NBITS-1:0]) : acc[NBITS-1:0];
            divByZero <= 1'b0;
            ovf       <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
